// File: rtl/bf_uart_fifo_bridge_if.sv
// Byte I/O bundle between brainfuck_core, the FIFO bridge and the AXI-stream uart.
// master = bridge side, slave = core/uart/environment side.
interface bf_uart_fifo_bridge_if #(
  parameter int CORE_DATA_WIDTH = 9,
  parameter int TX_DEPTH_LOG2   = 4,
  parameter int RX_DEPTH_LOG2   = 4
);
  logic [CORE_DATA_WIDTH-1:0] core_tx_data;
  logic                       core_tx_wr;
  logic                       core_tx_busy;
  logic [7:0]                 core_rx_data;
  logic                       core_rx_ready;
  logic                       core_rx_clear;
  logic [7:0]                 uart_tx_tdata;
  logic                       uart_tx_tvalid;
  logic                       uart_tx_busy;
  logic [7:0]                 uart_rx_tdata;
  logic                       uart_rx_tvalid;
  logic                       uart_rx_tready;
  logic [TX_DEPTH_LOG2:0]     tx_level;
  logic [RX_DEPTH_LOG2:0]     rx_level;

  modport master (
    input  core_tx_data, core_tx_wr, core_rx_clear,
    input  uart_tx_busy, uart_rx_tdata, uart_rx_tvalid,
    output core_tx_busy, core_rx_data, core_rx_ready,
    output uart_tx_tdata, uart_tx_tvalid, uart_rx_tready,
    output tx_level, rx_level
  );

  modport slave (
    output core_tx_data, core_tx_wr, core_rx_clear,
    output uart_tx_busy, uart_rx_tdata, uart_rx_tvalid,
    input  core_tx_busy, core_rx_data, core_rx_ready,
    input  uart_tx_tdata, uart_tx_tvalid, uart_rx_tready,
    input  tx_level, rx_level
  );
endinterface

// File: rtl/bf_uart_fifo_bridge.sv
// Buffered core<->uart byte bridge with TX/RX FIFOs; BF_UART_ECHO_EN adds local echo of received bytes.
// Latency: core write -> uart_tx_tvalid 1 cycle (uart idle); uart rx accept -> core_rx_ready 1 cycle.
// Backpressure: core_tx_busy while TX FIFO full; uart_rx_tready low while RX FIFO full (or echo slot held).
module bf_uart_fifo_bridge #(
  parameter int CORE_DATA_WIDTH = 9,
  parameter int TX_DEPTH_LOG2   = 4,
  parameter int RX_DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bf_uart_fifo_bridge_if.master io
);
  localparam int TX_DEPTH = 2 ** TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 2 ** RX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0] TX_LVL_MAX = (TX_DEPTH_LOG2+1)'(TX_DEPTH);
  localparam logic [RX_DEPTH_LOG2:0] RX_LVL_MAX = (RX_DEPTH_LOG2+1)'(RX_DEPTH);

  typedef enum logic [1:0] {T_IDLE, T_START, T_DONE} tx_state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]               tx_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr;
  logic [TX_DEPTH_LOG2-1:0] tx_rd_ptr;
  logic [TX_DEPTH_LOG2:0]   tx_level;
  logic [TX_DEPTH_LOG2:0]   tx_level_nxt;
  logic                     tx_full;
  logic                     core_push;
  logic                     tx_push;
  logic                     tx_pop;
  logic [7:0]               tx_push_dat;
  logic                     unused_core_bits;

  // Only the low byte is transmitted; upper core bits are intentionally dropped.
  assign unused_core_bits = ^io.core_tx_data;
  assign core_push        = io.core_tx_wr && !tx_full;

  // ---------------- RX FIFO ----------------
  logic [7:0]               rx_mem [RX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr;
  logic [RX_DEPTH_LOG2-1:0] rx_rd_ptr;
  logic [RX_DEPTH_LOG2:0]   rx_level;
  logic [RX_DEPTH_LOG2:0]   rx_level_nxt;
  logic                     rx_full;
  logic                     rx_rdy;
  logic                     rx_push;
  logic                     rx_pop;
  logic                     rx_hold;

`ifdef BF_UART_ECHO_EN
  // One-entry echo slot: the core has priority on the TX FIFO write port.
  logic       echo_vld;
  logic [7:0] echo_dat;
  logic       echo_push;

  assign echo_push   = echo_vld && !io.core_tx_wr && !tx_full;
  assign tx_push     = core_push || echo_push;
  assign tx_push_dat = core_push ? io.core_tx_data[7:0] : echo_dat;
  assign rx_hold     = echo_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_vld <= 1'b0;
      echo_dat <= 8'h00;
    end else if (rx_push) begin
      echo_vld <= 1'b1;
      echo_dat <= io.uart_rx_tdata;
    end else if (echo_push) begin
      echo_vld <= 1'b0;
    end
  end
`else
  assign tx_push     = core_push;
  assign tx_push_dat = io.core_tx_data[7:0];
  assign rx_hold     = 1'b0;
`endif

  always_comb begin
    tx_level_nxt = tx_level;
    if (tx_push && !tx_pop) begin
      tx_level_nxt = tx_level + 1'b1;
    end else if (!tx_push && tx_pop) begin
      tx_level_nxt = tx_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
      tx_full   <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_level <= tx_level_nxt;
      tx_full  <= (tx_level_nxt == TX_LVL_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_push_dat;
  end

  // ---------------- TX drain FSM ----------------
  tx_state_t tx_state;
  tx_state_t tx_state_nxt;
  logic      start_cnt;
  logic      start_cnt_nxt;
  logic      tx_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= T_IDLE;
      start_cnt <= 1'b0;
    end else begin
      tx_state  <= tx_state_nxt;
      start_cnt <= start_cnt_nxt;
    end
  end

  // T_START gives up after two cycles so a uart that never raises busy cannot hang the drain.
  always_comb begin
    tx_state_nxt  = tx_state;
    start_cnt_nxt = start_cnt;
    tx_fire       = 1'b0;
    tx_pop        = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if ((tx_level != '0) && !io.uart_tx_busy) begin
          tx_fire       = 1'b1;
          tx_pop        = 1'b1;
          start_cnt_nxt = 1'b0;
          tx_state_nxt  = T_START;
        end
      end
      T_START: begin
        if (io.uart_tx_busy) begin
          tx_state_nxt = T_DONE;
        end else if (start_cnt) begin
          tx_state_nxt = T_IDLE;
        end else begin
          start_cnt_nxt = 1'b1;
        end
      end
      T_DONE: begin
        if (!io.uart_tx_busy) tx_state_nxt = T_IDLE;
      end
      default: tx_state_nxt = T_IDLE;
    endcase
  end

  assign io.uart_tx_tvalid = tx_fire;
  assign io.uart_tx_tdata  = tx_fire ? tx_mem[tx_rd_ptr] : 8'h00;
  assign io.core_tx_busy   = tx_full;
  assign io.tx_level       = tx_level;

  // ---------------- RX path ----------------
  // tready is taken from the pre-pop level, so a full FIFO is never offered a byte.
  assign io.uart_rx_tready = !rx_full && !rst && !rx_hold;
  assign rx_push           = io.uart_rx_tvalid && io.uart_rx_tready;
  assign rx_rdy            = (rx_level != '0);
  assign rx_pop            = io.core_rx_clear && rx_rdy;

  always_comb begin
    rx_level_nxt = rx_level;
    if (rx_push && !rx_pop) begin
      rx_level_nxt = rx_level + 1'b1;
    end else if (!rx_push && rx_pop) begin
      rx_level_nxt = rx_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
      rx_full   <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_level <= rx_level_nxt;
      rx_full  <= (rx_level_nxt == RX_LVL_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= io.uart_rx_tdata;
  end

  assign io.core_rx_ready = rx_rdy;
  assign io.core_rx_data  = rx_rdy ? rx_mem[rx_rd_ptr] : 8'h00;
  assign io.rx_level      = rx_level;

endmodule

// File: tb/tb_bf_uart_fifo_bridge.sv
// Directed bench for bf_uart_fifo_bridge with TX/RX scoreboards and a small uart busy model.
module tb_bf_uart_fifo_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bf_uart_fifo_bridge_if #(.CORE_DATA_WIDTH(9), .TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) bif ();

  bf_uart_fifo_bridge #(.CORE_DATA_WIDTH(9), .TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) dut (
    .clk(clk),
    .rst(rst),
    .io (bif)
  );

  int checks = 0;
  int errors = 0;
  int tx_pulses = 0;
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  logic       busy_force = 1'b0;
  int         model_cnt = 0;

  // uart model: busy for a few cycles after every send pulse
  assign bif.uart_tx_busy = busy_force | (model_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (bif.uart_tx_tvalid) begin
      tx_pulses++;
      model_cnt <= 3;
      if (tx_q.size() == 0) chk("tx_unexpected", 32'(bif.uart_tx_tvalid), 32'd0);
      else chk("tx_data", 32'(bif.uart_tx_tdata), 32'(tx_q.pop_front()));
    end else if (model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
    end
    if (!rst && bif.uart_rx_tvalid && bif.uart_rx_tready) begin
      rx_q.push_back(bif.uart_rx_tdata);
`ifdef BF_UART_ECHO_EN
      tx_q.push_back(bif.uart_rx_tdata);
`endif
    end
  end

  task automatic core_wr(input logic [8:0] d, input bit expect_sent);
    bif.core_tx_wr   = 1'b1;
    bif.core_tx_data = d;
    if (expect_sent) tx_q.push_back(d[7:0]);
    tick();
    bif.core_tx_wr = 1'b0;
  endtask

  task automatic uart_send(input logic [7:0] b);
    bit ok = 1'b0;
    bif.uart_rx_tvalid = 1'b1;
    bif.uart_rx_tdata  = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = bif.uart_rx_tready;
      tick();
    end
    bif.uart_rx_tvalid = 1'b0;
    if (!ok) chk("rx_accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic core_pop(input string tag);
    chk(tag, 32'(bif.core_rx_data), 32'(rx_q.pop_front()));
    bif.core_rx_clear = 1'b1;
    tick();
    bif.core_rx_clear = 1'b0;
  endtask

  task automatic drain_tx(input string tag);
    int n = 0;
    while ((tx_q.size() != 0 || bif.tx_level != 0) && n < 800) begin
      tick();
      n++;
    end
    tick(8);
    chk(tag, 32'(tx_q.size()), 32'd0);
  endtask

  initial begin
    bif.core_tx_data   = '0;
    bif.core_tx_wr     = 1'b0;
    bif.core_rx_clear  = 1'b0;
    bif.uart_rx_tdata  = 8'h00;
    bif.uart_rx_tvalid = 1'b0;

    // reset state
    tick(3);
    chk("rst_tx_level", 32'(bif.tx_level), 32'd0);
    chk("rst_rx_level", 32'(bif.rx_level), 32'd0);
    chk("rst_tx_busy", 32'(bif.core_tx_busy), 32'd0);
    chk("rst_rx_ready", 32'(bif.core_rx_ready), 32'd0);
    chk("rst_tvalid", 32'(bif.uart_tx_tvalid), 32'd0);
    chk("rst_tdata", 32'(bif.uart_tx_tdata), 32'd0);
    chk("rst_rx_data", 32'(bif.core_rx_data), 32'd0);
    chk("rst_tready", 32'(bif.uart_rx_tready), 32'd0);
    rst = 1'b0;
    tick();
    chk("tready_after_rst", 32'(bif.uart_rx_tready), 32'd1);

    // 1: single write, upper bit dropped
    tx_pulses = 0;
    core_wr(9'h141, 1'b1);
    chk("t1_tvalid", 32'(bif.uart_tx_tvalid), 32'd1);
    chk("t1_tdata", 32'(bif.uart_tx_tdata), 32'h41);
    drain_tx("t1_drain");
    chk("t1_pulses", 32'(tx_pulses), 32'd1);
    chk("t1_level", 32'(bif.tx_level), 32'd0);

    // 2: fill TX while uart busy, overflow write ignored, then ordered drain
    busy_force = 1'b1;
    tick(2);
    for (int i = 0; i < 16; i++) begin
      core_wr(9'h100 | 9'(i), 1'b1);
      if (i == 14) chk("t2_busy_at15", 32'(bif.core_tx_busy), 32'd0);
    end
    chk("t2_busy_full", 32'(bif.core_tx_busy), 32'd1);
    chk("t2_level16", 32'(bif.tx_level), 32'd16);
    core_wr(9'h0AA, 1'b0);
    chk("t2_level_after17", 32'(bif.tx_level), 32'd16);
    tx_pulses = 0;
    busy_force = 1'b0;
    drain_tx("t2_drain");
    chk("t2_pulses", 32'(tx_pulses), 32'd16);
    chk("t2_busy_clear", 32'(bif.core_tx_busy), 32'd0);

    // 3: two received bytes, pop one at a time, clear on empty ignored
    uart_send(8'h55);
    uart_send(8'hAA);
    chk("t3_level2", 32'(bif.rx_level), 32'd2);
    chk("t3_ready", 32'(bif.core_rx_ready), 32'd1);
    core_pop("t3_data55");
    chk("t3_level1", 32'(bif.rx_level), 32'd1);
    core_pop("t3_dataAA");
    chk("t3_ready0", 32'(bif.core_rx_ready), 32'd0);
    bif.core_rx_clear = 1'b1;
    tick();
    bif.core_rx_clear = 1'b0;
    chk("t3_underflow", 32'(bif.rx_level), 32'd0);
    drain_tx("t3_drain");

`ifndef BF_UART_ECHO_EN
    // 4: RX full, pop + offer same cycle, then push+pop with level held
    for (int i = 0; i < 16; i++) uart_send(8'h80 + 8'(i));
    chk("t4_level16", 32'(bif.rx_level), 32'd16);
    chk("t4_tready0", 32'(bif.uart_rx_tready), 32'd0);
    chk("t4_head", 32'(bif.core_rx_data), 32'(rx_q.pop_front()));
    bif.core_rx_clear  = 1'b1;
    bif.uart_rx_tvalid = 1'b1;
    bif.uart_rx_tdata  = 8'hC0;
    tick();
    bif.core_rx_clear = 1'b0;
    chk("t4_level15", 32'(bif.rx_level), 32'd15);
    chk("t4_tready1", 32'(bif.uart_rx_tready), 32'd1);
    tick();
    bif.uart_rx_tvalid = 1'b0;
    chk("t4_level16b", 32'(bif.rx_level), 32'd16);
    for (int i = 0; i < 6; i++) core_pop("t4_pop");
    chk("t4_head_b", 32'(bif.core_rx_data), 32'(rx_q.pop_front()));
    bif.core_rx_clear  = 1'b1;
    bif.uart_rx_tvalid = 1'b1;
    bif.uart_rx_tdata  = 8'hD0;
    tick();
    bif.core_rx_clear  = 1'b0;
    bif.uart_rx_tvalid = 1'b0;
    chk("t4_level_same", 32'(bif.rx_level), 32'd10);
    for (int i = 0; i < 10; i++) core_pop("t4_pop_tail");
    chk("t4_empty", 32'(bif.core_rx_ready), 32'd0);
`endif

    // 5: reset with data buffered in both FIFOs
    busy_force = 1'b1;
    tick(2);
    for (int i = 0; i < 5; i++) core_wr(9'h020 + 9'(i), 1'b0);
    for (int i = 0; i < 3; i++) uart_send(8'h30 + 8'(i));
`ifndef BF_UART_ECHO_EN
    chk("t5_tx_level5", 32'(bif.tx_level), 32'd5);
`endif
    chk("t5_rx_level3", 32'(bif.rx_level), 32'd3);
    rst = 1'b1;
    tick();
    chk("t5_tready_in_rst", 32'(bif.uart_rx_tready), 32'd0);
    rst = 1'b0;
    tx_q.delete();
    rx_q.delete();
    chk("t5_tx_level0", 32'(bif.tx_level), 32'd0);
    chk("t5_rx_level0", 32'(bif.rx_level), 32'd0);
    chk("t5_rx_ready0", 32'(bif.core_rx_ready), 32'd0);
    tx_pulses = 0;
    busy_force = 1'b0;
    tick(40);
    chk("t5_no_tvalid", 32'(tx_pulses), 32'd0);

`ifdef BF_UART_ECHO_EN
    // 6: core write and uart receive in the same cycle; core byte goes first
    tx_pulses = 0;
    bif.core_tx_wr     = 1'b1;
    bif.core_tx_data   = 9'h061;
    tx_q.push_back(8'h61);
    bif.uart_rx_tvalid = 1'b1;
    bif.uart_rx_tdata  = 8'h62;
    tick();
    bif.core_tx_wr     = 1'b0;
    bif.uart_rx_tvalid = 1'b0;
    drain_tx("t6_drain");
    chk("t6_pulses", 32'(tx_pulses), 32'd2);
    chk("t6_rx_level", 32'(bif.rx_level), 32'd1);
    core_pop("t6_rx62");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
